// File: rtl/data_types_pkg.sv
// Shared types for the I2C environment.
//   i2c_op_t           : transfer direction taken from the address byte LSB
//   i2c_slave_state_t  : responder FSM states
//   I2C_ACK / I2C_NACK : SDA level of the acknowledge bit
package data_types_pkg;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } i2c_op_t;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_LOAD,
    RD_BYTE,
    RD_MACK,
    IGNORE
  } i2c_slave_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the resolved SCL/SDA bus wires into clk_i and flags bus events.
//   scl_i, sda_i : raw bus levels
//   scl_s, sda_s : synchronized levels, aligned with the flags below
//   scl_rise     : SCL went high          scl_fall  : SCL went low
//   start_det    : SDA fell while SCL high stop_det : SDA rose while SCL high
// A pin edge shows up on its flag SYNC_STAGES+1 cycles later.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_p0;
  logic [SYNC_STAGES-1:0] sda_sync_p0;
  logic                   scl_hist_p1;
  logic                   sda_hist_p1;
  logic                   scl_cur;
  logic                   sda_cur;

  assign scl_cur = scl_sync_p0[SYNC_STAGES-1];
  assign sda_cur = sda_sync_p0[SYNC_STAGES-1];

  // Flops reset to the idle bus level so reset release never fakes an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
      scl_hist_p1 <= 1'b1;
      sda_hist_p1 <= 1'b1;
      scl_rise    <= 1'b0;
      scl_fall    <= 1'b0;
      start_det   <= 1'b0;
      stop_det    <= 1'b0;
    end else begin
      // stage p0: metastability chain
      scl_sync_p0[0] <= scl_i;
      sda_sync_p0[0] <= sda_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_p0[i] <= scl_sync_p0[i-1];
        sda_sync_p0[i] <= sda_sync_p0[i-1];
      end
      // stage p1: history plus registered edge/condition flags
      scl_hist_p1 <= scl_cur;
      sda_hist_p1 <= sda_cur;
      scl_rise    <= scl_cur & ~scl_hist_p1;
      scl_fall    <= ~scl_cur & scl_hist_p1;
      start_det   <= scl_cur & scl_hist_p1 & sda_hist_p1 & ~sda_cur;
      stop_det    <= scl_cur & scl_hist_p1 & ~sda_hist_p1 & sda_cur;
    end
  end

  // The history flops hold the level that the registered flags describe.
  assign scl_s = scl_hist_p1;
  assign sda_s = sda_hist_p1;

endmodule

// File: rtl/i2c_slave_rsp.sv
// I2C target answering a single address.
//   clk_i, rst_i          : system clock (>= 8x SCL), async active-high reset
//   scl_i, sda_i          : resolved bus wires
//   scl_o, sda_o          : open-drain drives, 0 = pull low, 1 = release
//   rx_data_o, rx_valid_o : last master-written byte, one-cycle strobe
//   tx_data_i, tx_valid_i : byte to return on a master read
//   tx_ready_o            : byte is consumed in the cycle this is high
//   op_o                  : direction of the current transfer
//   busy_o                : addressed, until STOP
module i2c_slave_rsp
  import data_types_pkg::*;
#(
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
  parameter int                        SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o,
  output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
  output logic                      rx_valid_o,
  input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output i2c_op_t                   op_o,
  output logic                      busy_o
);

  localparam int                CNT_W    = $clog2(I2C_DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(I2C_DATA_WIDTH - 1);

  logic                      scl_s;
  logic                      sda_s;
  logic                      scl_rise;
  logic                      scl_fall;
  logic                      start_det;
  logic                      stop_det;

  i2c_slave_state_t          state;
  logic [CNT_W-1:0]          bit_cnt;
  logic [I2C_DATA_WIDTH-1:0] shreg;
  logic [I2C_DATA_WIDTH-1:0] shreg_in;
  logic                      ack_pend;
  logic                      addr_hit;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_s    (scl_s),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign shreg_in = {shreg[I2C_DATA_WIDTH-2:0], sda_s};
  assign addr_hit = (shreg_in[I2C_DATA_WIDTH-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR);

  // Ready is combinational so the capture and the handshake share one cycle.
  // Only load while SCL is really low so SDA never moves under a high clock.
  assign tx_ready_o = (state == RD_LOAD) && tx_valid_i && !scl_s && !start_det && !stop_det;

  // ack_pend marks "byte/ack bit sampled, act on the coming SCL fall".
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      ack_pend   <= 1'b0;
      scl_o      <= 1'b1;
      sda_o      <= 1'b1;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      op_o       <= WRITE;
      busy_o     <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      if (stop_det) begin
        state    <= IDLE;
        ack_pend <= 1'b0;
        scl_o    <= 1'b1;
        sda_o    <= 1'b1;
        busy_o   <= 1'b0;
      end else if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        ack_pend <= 1'b0;
        scl_o    <= 1'b1;
        sda_o    <= 1'b1;
      end else begin
        unique case (state)
          IDLE, IGNORE: begin
          end
          ADDR: begin
            if (scl_rise && !ack_pend) begin
              shreg   <= shreg_in;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                if (addr_hit) begin
                  op_o     <= i2c_op_t'(shreg_in[0]);
                  busy_o   <= 1'b1;
                  ack_pend <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end
            end else if (scl_fall && ack_pend) begin
              sda_o    <= I2C_ACK;
              ack_pend <= 1'b0;
              state    <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_o   <= I2C_NACK;
              bit_cnt <= '0;
              if (op_o == READ) begin
                // Hold SCL from the start of the low phase until data is in.
                scl_o <= 1'b0;
                state <= RD_LOAD;
              end else begin
                state <= WR_BYTE;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise && !ack_pend) begin
              shreg   <= shreg_in;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                rx_data_o  <= shreg_in;
                rx_valid_o <= 1'b1;
                ack_pend   <= 1'b1;
              end
            end else if (scl_fall && ack_pend) begin
              sda_o    <= I2C_ACK;
              ack_pend <= 1'b0;
              state    <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_o   <= I2C_NACK;
              bit_cnt <= '0;
              state   <= WR_BYTE;
            end
          end
          RD_LOAD: begin
            if (tx_ready_o) begin
              sda_o   <= tx_data_i[I2C_DATA_WIDTH-1];
              shreg   <= {tx_data_i[I2C_DATA_WIDTH-2:0], 1'b0};
              bit_cnt <= '0;
              scl_o   <= 1'b1;
              state   <= RD_BYTE;
            end else begin
              scl_o <= 1'b0;
            end
          end
          RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == LAST_BIT) begin
                sda_o <= I2C_NACK;
                state <= RD_MACK;
              end else begin
                sda_o   <= shreg[I2C_DATA_WIDTH-1];
                shreg   <= {shreg[I2C_DATA_WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          RD_MACK: begin
            if (scl_rise && !ack_pend) begin
              if (sda_s == I2C_ACK) ack_pend <= 1'b1;
              else                  state    <= IGNORE;
            end else if (scl_fall && ack_pend) begin
              ack_pend <= 1'b0;
              scl_o    <= 1'b0;
              state    <= RD_LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
